// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register word offsets, mode encodings and CTRL bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } timer_state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PS_LO   = 8;
  localparam int CTRL_PS_HI   = 15;

  // Only the exact auto-reload encoding reloads; 1x falls back to one-shot.
  function automatic logic is_auto_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Rate divider for the countdown: tick fires once every (ps+1) cycles unless cleared.
// Only built with TIMER_PRESCALE_EN; without it the timer ties its tick high.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [7:0] ps,
  output logic       tick
);

  logic [7:0] div_cnt;

  assign tick = (div_cnt == ps);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= 8'd0;
    end else if (clr || tick) begin
      div_cnt <= 8'd0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit countdown timer (one-shot / auto-reload) feeding the CP0 irq.
// Defining TIMER_PRESCALE_EN adds the CTRL[15:8] prescaler field.
module timer_counter
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  timer_state_t state;
  logic         ctrl_en;
  logic [1:0]   ctrl_mode;
  logic         ctrl_im;
  logic [7:0]   ctrl_ps;
  logic [31:0]  preset;
  logic [31:0]  count;
  logic         pending;
  logic         tick;
  logic         wr_ctrl;
  logic         wr_preset;
  logic         terminal;
  logic         unused_addr;

  assign wr_ctrl   = sel & we & (addr[3:2] == OFF_CTRL);
  assign wr_preset = sel & we & (addr[3:2] == OFF_PRESET);
  assign terminal  = (state == S_CNT) & ctrl_en & tick & (count <= 32'd1);
  assign irq       = ctrl_im & pending;

  // The bridge decodes the window; only the word offset matters here.
  assign unused_addr = ^{addr[31:4], addr[1:0], BASE_ADDR};

`ifdef TIMER_PRESCALE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_ps <= 8'd0;
    end else if (wr_ctrl) begin
      ctrl_ps <= wd[CTRL_PS_HI:CTRL_PS_LO];
    end
  end

  timer_prescaler u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (state != S_CNT),
    .ps   (ctrl_ps),
    .tick (tick)
  );
`else
  assign ctrl_ps = 8'd0;
  assign tick    = 1'b1;
`endif

  // CTRL write is applied after the FSM so the bus wins the EN/MODE/IM race.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      ctrl_im   <= 1'b0;
      preset    <= 32'd0;
      count     <= 32'd0;
      pending   <= 1'b0;
    end else begin
      if (wr_preset) begin
        preset <= wd;
      end

      case (state)
        S_IDLE: begin
          if (ctrl_en) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!ctrl_en) begin
            state <= S_IDLE;
          end else if (terminal) begin
            count <= 32'd0;
            state <= S_INT;
          end else if (tick) begin
            count <= count - 32'd1;
          end
        end
        S_INT: begin
          if (is_auto_reload(ctrl_mode)) begin
            state <= ctrl_en ? S_LOAD : S_IDLE;
          end else begin
            ctrl_en <= 1'b0;
            state   <= S_IDLE;
          end
        end
      endcase

      if (wr_ctrl) begin
        ctrl_en   <= wd[CTRL_EN];
        ctrl_mode <= wd[CTRL_MODE_HI:CTRL_MODE_LO];
        ctrl_im   <= wd[CTRL_IM];
      end

      pending <= terminal | (pending & ~wr_ctrl);
    end
  end

  always_comb begin
    rd = 32'd0;
    case (addr[3:2])
      OFF_CTRL: begin
        rd[CTRL_EN]                 = ctrl_en;
        rd[CTRL_MODE_HI:CTRL_MODE_LO] = ctrl_mode;
        rd[CTRL_IM]                 = ctrl_im;
        rd[CTRL_PS_HI:CTRL_PS_LO]   = ctrl_ps;
      end
      OFF_PRESET: rd = preset;
      OFF_COUNT:  rd = count;
      default:    rd = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed bus writes with hand-computed expectations,
// checked by a queue-based scoreboard monitor independent of the stimulus.
module tb_timer_counter;
  import timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } expect_t;

  expect_t exp_q[$];
  int      checks = 0;
  int      passed = 0;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .sel  (sel),
    .we   (we),
    .addr (addr),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: pops one expectation per falling clock (or async reset).
  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge clk or negedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rd === e.exp_rd) passed++;
        else $display("[TB] FAIL %s rd: got %h, expected %h", e.name, rd, e.exp_rd);
        checks++;
        if (irq === e.exp_irq) passed++;
        else $display("[TB] FAIL %s irq: got %b, expected %b", e.name, irq, e.exp_irq);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic stepEdges(input int n);
    for (int i = 0; i < n; i++) stepEdge();
  endtask

  task automatic setAddr(input logic [1:0] off);
    addr = BASE + {28'd0, off, 2'b00};
  endtask

  task automatic applyStimulus(input logic [1:0] off, input logic [31:0] data);
    setAddr(off);
    wd  = data;
    sel = 1'b1;
    we  = 1'b1;
    stepEdge();
    sel = 1'b0;
    we  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_rd, input logic exp_irq);
    expect_t e;
    e.name    = name;
    e.exp_rd  = exp_rd;
    e.exp_irq = exp_irq;
    exp_q.push_back(e);
    @(negedge clk);
    #2;
  endtask

  initial begin : stimulus
    logic [31:0] exp_wide_ctrl;
    reset = 1'b0;
    sel   = 1'b0;
    we    = 1'b0;
    wd    = 32'd0;
    addr  = BASE;
    stepEdge();
    checkOutput("reset_ctrl", 32'd0, 1'b0);
    setAddr(OFF_PRESET);
    checkOutput("reset_preset", 32'd0, 1'b0);
    setAddr(OFF_COUNT);
    checkOutput("reset_count", 32'd0, 1'b0);
    reset = 1'b1;
    stepEdge();

    // One-shot, PRESET=3, IM=1: irq after edge 5, EN self-clears.
    applyStimulus(OFF_PRESET, 32'd3);
    applyStimulus(OFF_CTRL, 32'h9);
    checkOutput("os_ctrl_e0", 32'h9, 1'b0);
    setAddr(OFF_COUNT);
    stepEdges(2);
    checkOutput("os_count_e2", 32'd3, 1'b0);
    stepEdges(2);
    checkOutput("os_count_e4", 32'd1, 1'b0);
    stepEdge();
    checkOutput("os_irq_e5", 32'd0, 1'b1);
    stepEdge();
    setAddr(OFF_CTRL);
    checkOutput("os_ctrl_e6", 32'h8, 1'b1);
    stepEdge();
    checkOutput("os_irq_hold", 32'h8, 1'b1);
    applyStimulus(OFF_CTRL, 32'h8);
    checkOutput("os_ack", 32'h8, 1'b0);
    setAddr(2'd3);
    checkOutput("reserved_rd", 32'd0, 1'b0);
    setAddr(OFF_PRESET);
    wd = 32'h55;
    we = 1'b1;
    stepEdge();
    we = 1'b0;
    checkOutput("unselected_write", 32'd3, 1'b0);

    // Auto-reload, PRESET=4: INT every 6 edges, irq held until a CTRL write.
    applyStimulus(OFF_PRESET, 32'd4);
    applyStimulus(OFF_CTRL, 32'hB);
    setAddr(OFF_COUNT);
    stepEdges(5);
    checkOutput("ar_count_e5", 32'd1, 1'b0);
    stepEdge();
    checkOutput("ar_int_e6", 32'd0, 1'b1);
    stepEdge();
    checkOutput("ar_load_e7", 32'd0, 1'b1);
    stepEdge();
    checkOutput("ar_count_e8", 32'd4, 1'b1);
    applyStimulus(OFF_CTRL, 32'hB);
    checkOutput("ar_ack_e9", 32'hB, 1'b0);
    stepEdge();
    setAddr(OFF_COUNT);
    checkOutput("ar_count_e10", 32'd2, 1'b0);
    stepEdge();
    checkOutput("ar_count_e11", 32'd1, 1'b0);
    stepEdge();
    checkOutput("ar_int_e12", 32'd0, 1'b1);
    applyStimulus(OFF_CTRL, 32'h0);
    checkOutput("ar_stop", 32'h0, 1'b0);
    stepEdges(2);
    setAddr(OFF_COUNT);
    checkOutput("ar_frozen", 32'd4, 1'b0);
    stepEdge();
    checkOutput("ar_frozen_idle", 32'd4, 1'b0);

    // Masked, PRESET=0: reaches 0 without wrapping, irq never rises.
    applyStimulus(OFF_PRESET, 32'd0);
    applyStimulus(OFF_CTRL, 32'h1);
    setAddr(OFF_COUNT);
    stepEdge();
    checkOutput("mask_load_e1", 32'd4, 1'b0);
    stepEdge();
    checkOutput("mask_count_e2", 32'd0, 1'b0);
    stepEdge();
    checkOutput("mask_nowrap_e3", 32'd0, 1'b0);
    stepEdge();
    setAddr(OFF_CTRL);
    checkOutput("mask_en_cleared", 32'h0, 1'b0);
    applyStimulus(OFF_CTRL, 32'h8);
    checkOutput("mask_ack", 32'h8, 1'b0);

    // Disable mid-count, COUNT write ignored, PRESET write only at next LOAD.
    applyStimulus(OFF_PRESET, 32'd10);
    applyStimulus(OFF_CTRL, 32'h9);
    setAddr(OFF_COUNT);
    stepEdges(5);
    checkOutput("dis_count7", 32'd7, 1'b0);
    applyStimulus(OFF_CTRL, 32'h0);
    checkOutput("dis_ctrl", 32'h0, 1'b0);
    stepEdge();
    setAddr(OFF_COUNT);
    checkOutput("dis_frozen6", 32'd6, 1'b0);
    stepEdge();
    checkOutput("dis_still6", 32'd6, 1'b0);
    applyStimulus(OFF_COUNT, 32'hDEAD);
    checkOutput("count_wr_ignored", 32'd6, 1'b0);
    applyStimulus(OFF_CTRL, 32'h9);
    setAddr(OFF_COUNT);
    stepEdges(2);
    checkOutput("reen_reload10", 32'd10, 1'b0);
    applyStimulus(OFF_PRESET, 32'd2);
    checkOutput("preset_mid_cnt", 32'd2, 1'b0);
    setAddr(OFF_COUNT);
    stepEdge();
    checkOutput("preset_no_reload", 32'd8, 1'b0);
    applyStimulus(OFF_CTRL, 32'h0);
    stepEdges(2);
    applyStimulus(OFF_CTRL, 32'h9);
    setAddr(OFF_COUNT);
    stepEdges(2);
    checkOutput("new_preset_load", 32'd2, 1'b0);
    stepEdge();
    applyStimulus(OFF_CTRL, 32'h9);
    checkOutput("set_beats_clear", 32'h9, 1'b1);
    applyStimulus(OFF_CTRL, 32'h9);
    checkOutput("bus_beats_fsm_en", 32'h9, 1'b0);
    setAddr(OFF_COUNT);
    stepEdges(4);
    checkOutput("rerun_int", 32'd0, 1'b1);
    applyStimulus(OFF_CTRL, 32'h8);
    checkOutput("rerun_ack", 32'h8, 1'b0);

    // Asynchronous reset in CNT with COUNT=5 and irq high.
    applyStimulus(OFF_PRESET, 32'd5);
    applyStimulus(OFF_CTRL, 32'hB);
    setAddr(OFF_COUNT);
    stepEdges(9);
    checkOutput("pre_reset_count5", 32'd5, 1'b1);
    begin
      expect_t e;
      e.name    = "async_reset";
      e.exp_rd  = 32'd0;
      e.exp_irq = 1'b0;
      exp_q.push_back(e);
      reset = 1'b0;
      #2;
    end
    setAddr(OFF_CTRL);
    checkOutput("rst_ctrl_mid", 32'd0, 1'b0);
    setAddr(OFF_PRESET);
    checkOutput("rst_preset_mid", 32'd0, 1'b0);
    reset = 1'b1;
    stepEdge();
    applyStimulus(OFF_PRESET, 32'd2);
    applyStimulus(OFF_CTRL, 32'h1);
    setAddr(OFF_COUNT);
    stepEdges(2);
    checkOutput("post_reset_idle_timing", 32'd2, 1'b0);

    // Unimplemented CTRL bits read back as zero (PS only when compiled in).
`ifdef TIMER_PRESCALE_EN
    exp_wide_ctrl = 32'h0000_FF00;
`else
    exp_wide_ctrl = 32'h0000_0000;
`endif
    applyStimulus(OFF_CTRL, 32'hFFFF_FFF0);
    checkOutput("ctrl_ignored_bits", exp_wide_ctrl, 1'b0);
    stepEdges(2);
    applyStimulus(OFF_CTRL, 32'h0);

`ifdef TIMER_PRESCALE_EN
    // PS=2, PRESET=2, one-shot: irq after edge 8.
    applyStimulus(OFF_PRESET, 32'd2);
    applyStimulus(OFF_CTRL, 32'h209);
    checkOutput("ps_ctrl", 32'h209, 1'b0);
    setAddr(OFF_COUNT);
    stepEdges(7);
    checkOutput("ps_count_e7", 32'd1, 1'b0);
    applyStimulus(OFF_COUNT, 32'hDEAD);
    checkOutput("ps_irq_e8", 32'd0, 1'b1);
`endif

    stepEdge();
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
